// File: rtl/alu_arbiter.sv
// -----------------------------------------------------------------------------
// alu_arbiter
//
// Shares one external combinational ALU between two requesters (for example
// the EX stage and the branch/address unit). Arbitration is round-robin, and
// only one transaction is in flight at a time. Operands are registered on
// accept and drive the ALU directly. One cycle later the ALU output is
// captured into the owning requester's response registers.
//
// ALU opcodes: 0 add, 1 sub, 2 mul, 3 div, 4 and, 5 or, 6 xor.
//
// Handshakes (request and response channels):
//   A transfer happens on a rising clock edge where valid && ready are both
//   high. The source holds its payload stable while valid is high and ready
//   is low. The sink may raise or lower ready regardless of valid. A source
//   may withdraw valid without a transfer; nothing is recorded in that case.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   rN_valid / rN_ready        request channel of requester N (N = 0, 1)
//   rN_op, rN_a, rN_b          request payload, sampled on accept
//   rN_rsp_valid / _ready      response channel of requester N
//   rN_result/_zero/_illegal   response payload; held after consumption
//   alu_op, alu_a, alu_b       registered operands driven to the ALU
//   alu_c, alu_zero            ALU outputs
//   busy                       a transaction is in flight (state != IDLE)
//   state_dbg                  raw FSM state, for observation only
//
// Timing
//   Accept in cycle T. The ALU evaluates in T+1. The response is visible
//   from T+2. Back-to-back accepts are at least 3 cycles apart.
// -----------------------------------------------------------------------------
module alu_arbiter #(
  parameter int WIDTH  = 32,
  parameter int OPW    = 4,
  parameter int MAX_OP = 6
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             r0_valid,
  output logic             r0_ready,
  input  logic [OPW-1:0]   r0_op,
  input  logic [WIDTH-1:0] r0_a,
  input  logic [WIDTH-1:0] r0_b,
  output logic             r0_rsp_valid,
  input  logic             r0_rsp_ready,
  output logic [WIDTH-1:0] r0_result,
  output logic             r0_zero,
  output logic             r0_illegal,

  input  logic             r1_valid,
  output logic             r1_ready,
  input  logic [OPW-1:0]   r1_op,
  input  logic [WIDTH-1:0] r1_a,
  input  logic [WIDTH-1:0] r1_b,
  output logic             r1_rsp_valid,
  input  logic             r1_rsp_ready,
  output logic [WIDTH-1:0] r1_result,
  output logic             r1_zero,
  output logic             r1_illegal,

  output logic [OPW-1:0]   alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_c,
  input  logic             alu_zero,

  output logic             busy,
  output logic [1:0]       state_dbg
);

  localparam logic [OPW-1:0] MAX_OP_C = OPW'(MAX_OP);
  localparam logic [OPW-1:0] OP_DIV   = OPW'(3);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;

  logic             last_grant;   // requester served most recently
  logic             owner;        // requester of the transaction in flight
  logic             grant;        // requester offered ready while idle
  logic             accept;
  logic             consume;
  logic             own_rsp_valid;
  logic             own_rsp_ready;

  logic             cap_illegal;
  logic [WIDTH-1:0] cap_result;
  logic             cap_zero;

  // ---------------------------------------------------------------------------
  // Arbitration. A lone requester always wins. When both are valid, the one
  // not served last wins. With no requester valid, the offer still rotates,
  // so ready never depends on an idle requester's valid.
  // ---------------------------------------------------------------------------
  always_comb begin
    grant = ~last_grant;
    if (r0_valid && !r1_valid) begin
      grant = 1'b0;
    end else if (!r0_valid && r1_valid) begin
      grant = 1'b1;
    end
  end

  assign r0_ready = (state == IDLE) && !grant;
  assign r1_ready = (state == IDLE) &&  grant;

  assign accept = (r0_valid && r0_ready) || (r1_valid && r1_ready);

  assign own_rsp_valid = owner ? r1_rsp_valid : r0_rsp_valid;
  assign own_rsp_ready = owner ? r1_rsp_ready : r0_rsp_ready;
  assign consume       = (state == RESP) && own_rsp_valid && own_rsp_ready;

  // ---------------------------------------------------------------------------
  // Result capture. Illegal opcodes and divide-by-zero override whatever the
  // ALU produced: the result is forced to 0 with zero set.
  // ---------------------------------------------------------------------------
  always_comb begin
    cap_illegal = (alu_op > MAX_OP_C) || ((alu_op == OP_DIV) && (alu_b == '0));
    cap_result  = alu_c;
    cap_zero    = alu_zero;
    if (cap_illegal) begin
      cap_result = '0;
      cap_zero   = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = ISSUE;
      ISSUE:   state_nxt = RESP;
      RESP:    if (consume) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

  // ---------------------------------------------------------------------------
  // Datapath registers. Reset drops any in-flight transaction and clears
  // every registered output. last_grant resets to 1 so r0 wins the first
  // contention.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant   <= 1'b1;
      owner        <= 1'b0;
      alu_op       <= '0;
      alu_a        <= '0;
      alu_b        <= '0;
      r0_rsp_valid <= 1'b0;
      r0_result    <= '0;
      r0_zero      <= 1'b0;
      r0_illegal   <= 1'b0;
      r1_rsp_valid <= 1'b0;
      r1_result    <= '0;
      r1_zero      <= 1'b0;
      r1_illegal   <= 1'b0;
    end else begin
      if (accept) begin
        owner      <= grant;
        last_grant <= grant;
        alu_op     <= grant ? r1_op : r0_op;
        alu_a      <= grant ? r1_a  : r0_a;
        alu_b      <= grant ? r1_b  : r0_b;
      end

      // The ALU sees the registered operands throughout ISSUE.
      if (state == ISSUE) begin
        if (owner) begin
          r1_result    <= cap_result;
          r1_zero      <= cap_zero;
          r1_illegal   <= cap_illegal;
          r1_rsp_valid <= 1'b1;
        end else begin
          r0_result    <= cap_result;
          r0_zero      <= cap_zero;
          r0_illegal   <= cap_illegal;
          r0_rsp_valid <= 1'b1;
        end
      end

      // The payload is deliberately left in place after consumption.
      if (consume) begin
        if (owner) begin
          r1_rsp_valid <= 1'b0;
        end else begin
          r0_rsp_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_alu_arbiter
//
// Bench for alu_arbiter. A combinational ALU model drives alu_c/alu_zero.
// A transaction-level reference checks every DUT output on each falling edge.
// The reference tracks whether a request is in flight, how many cycles have
// passed since it was accepted, and the last payload delivered to each
// requester. Directed scenarios add literal expectations, followed by a
// randomized phase.
// -----------------------------------------------------------------------------
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  valid, ready, rsp_valid, rsp_ready, zero, ill;
  logic [3:0]  op_in [2];
  logic [31:0] a_in [2];
  logic [31:0] b_in [2];
  logic [31:0] res0, res1;
  logic [3:0]  alu_op;
  logic [31:0] alu_a, alu_b, alu_c;
  logic        alu_zero, busy;
  logic [1:0]  state_dbg;

  int nvec  = 0;
  int nfail = 0;
  int cyc   = 0;
  int acc_cyc = 0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT and ALU model ----------------
  alu_arbiter #(.WIDTH(32), .OPW(4), .MAX_OP(6)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(valid[0]), .r0_ready(ready[0]), .r0_op(op_in[0]), .r0_a(a_in[0]), .r0_b(b_in[0]),
    .r0_rsp_valid(rsp_valid[0]), .r0_rsp_ready(rsp_ready[0]),
    .r0_result(res0), .r0_zero(zero[0]), .r0_illegal(ill[0]),
    .r1_valid(valid[1]), .r1_ready(ready[1]), .r1_op(op_in[1]), .r1_a(a_in[1]), .r1_b(b_in[1]),
    .r1_rsp_valid(rsp_valid[1]), .r1_rsp_ready(rsp_ready[1]),
    .r1_result(res1), .r1_zero(zero[1]), .r1_illegal(ill[1]),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c), .alu_zero(alu_zero),
    .busy(busy), .state_dbg(state_dbg)
  );

  // The external ALU returns junk for illegal cases, so the DUT override is visible.
  function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a * b;
      4'd3:    return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      4'd4:    return a & b;
      4'd5:    return a | b;
      4'd6:    return a ^ b;
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  assign alu_c    = alu_fn(alu_op, alu_a, alu_b);
  assign alu_zero = (alu_c == 32'd0);

  // ---------------- reference ----------------
  // Packed response word: {illegal, zero, result}.
  function automatic logic [33:0] ref_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    if (op > 4'd6 || (op == 4'd3 && b == 32'd0)) return {1'b1, 1'b1, 32'd0};
    case (op)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = a * b;
      4'd3:    r = a / b;
      4'd4:    r = a & b;
      4'd5:    r = a | b;
      default: r = a ^ b;
    endcase
    return {1'b0, (r == 32'd0), r};
  endfunction

  bit          armed = 1'b0;
  bit          m_busy;
  int          m_age;
  int          m_owner;
  int          m_last;
  logic [3:0]  m_op;
  logic [31:0] m_a, m_b;
  logic [33:0] m_pend;
  logic [33:0] m_shown [2];
  logic [33:0] exp_q [$];
  int          acc_log [$];

  function automatic logic [31:0] res_of(input int n);
    return (n == 1) ? res1 : res0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_busy = 1'b0; m_age = 0; m_owner = 0; m_last = 1;
    m_op = 4'd0; m_a = 32'd0; m_b = 32'd0; m_pend = 34'd0;
    m_shown[0] = 34'd0; m_shown[1] = 34'd0;
    exp_q.delete();
  endfunction

  function automatic int pick(input logic [1:0] v, input int last);
    if (v == 2'b01) return 0;
    if (v == 2'b10) return 1;
    return 1 - last;
  endfunction

  task automatic compare_cycle();
    logic [33:0] e;
    int g;
    chk("busy", 32'(busy), 32'(m_busy));
    for (int n = 0; n < 2; n++) begin
      chk("rsp_valid", 32'(rsp_valid[n]), 32'(m_busy && m_age >= 2 && m_owner == n));
      chk("result", res_of(n), m_shown[n][31:0]);
      chk("zero", 32'(zero[n]), 32'(m_shown[n][32]));
      chk("illegal", 32'(ill[n]), 32'(m_shown[n][33]));
    end
    chk("alu_op", 32'(alu_op), 32'(m_op));
    chk("alu_a", alu_a, m_a);
    chk("alu_b", alu_b, m_b);
    if (m_busy) begin
      chk("ready_busy", 32'(ready), 32'd0);
    end else if (valid != 2'b00) begin
      g = pick(valid, m_last);
      chk("ready_grant", 32'(ready), (g == 1) ? 32'd2 : 32'd1);
    end

    // Advance to the state after the coming rising edge.
    if (rst) begin
      model_reset();
    end else if (!m_busy) begin
      if (valid != 2'b00) begin
        g = pick(valid, m_last);
        m_busy = 1'b1; m_age = 1; m_owner = g; m_last = g;
        m_op = op_in[g]; m_a = a_in[g]; m_b = b_in[g];
        m_pend = ref_fn(op_in[g], a_in[g], b_in[g]);
        exp_q.push_back(m_pend);
      end
    end else if (m_age == 1) begin
      m_age = 2;
      m_shown[m_owner] = m_pend;
    end else if (rsp_ready[m_owner]) begin
      if (exp_q.size() == 0) begin
        chk("scoreboard_empty", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("sb_result", res_of(m_owner), e[31:0]);
        chk("sb_flags", 32'({ill[m_owner], zero[m_owner]}), 32'(e[33:32]));
      end
      m_busy = 1'b0;
    end
  endtask

  // Compare process: every falling edge once reset has been seen.
  initial begin
    forever begin
      @(negedge clk);
      if (!armed) begin
        if (rst === 1'b1) begin
          model_reset();
          armed = 1'b1;
        end
      end else begin
        if (!rst) begin
          if (valid[0] && ready[0]) acc_log.push_back(0);
          if (valid[1] && ready[1]) acc_log.push_back(1);
        end
        compare_cycle();
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int n, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input string name);
    bit got = 1'b0;
    op_in[n] = op; a_in[n] = a; b_in[n] = b; valid[n] = 1'b1;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (ready[n]) begin
        got = 1'b1;
        acc_cyc = cyc;
      end
      @(posedge clk); #1;
    end
    valid[n] = 1'b0;
    chk({name, "_accept"}, 32'(got), 32'd1);
  endtask

  task automatic wait_rsp(input int n, input logic [31:0] r, input logic z, input logic il,
                          input string name, output int lat);
    bit got = 1'b0;
    lat = -1;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge clk);
      if (rsp_valid[n]) begin
        if (lat < 0) lat = cyc - acc_cyc;
        if (rsp_ready[n]) begin
          got = 1'b1;
          chk({name, "_result"}, res_of(n), r);
          chk({name, "_zero"}, 32'(zero[n]), 32'(z));
          chk({name, "_illegal"}, 32'(ill[n]), 32'(il));
        end
      end
      @(posedge clk); #1;
    end
    chk({name, "_response"}, 32'(got), 32'd1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int  lat;
    bit  ok;
    rst = 1'b1; valid = 2'b00; rsp_ready = 2'b11;
    for (int n = 0; n < 2; n++) begin op_in[n] = 4'd0; a_in[n] = 32'd0; b_in[n] = 32'd0; end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Single add; latency from accept to response is 2.
    send(0, 4'd0, 32'd5, 32'd7, "t1");
    wait_rsp(0, 32'd12, 1'b0, 1'b0, "t1", lat);
    chk("t1_latency", 32'(lat), 32'd2);

    // Fresh reset, both requesters valid: r0 first, then alternation.
    rst = 1'b1; @(posedge clk); #1 rst = 1'b0;
    acc_log.delete();
    op_in[0] = 4'd1; a_in[0] = 32'd3;    b_in[0] = 32'd3;
    op_in[1] = 4'd6; a_in[1] = 32'hF0;   b_in[1] = 32'h0F;
    valid = 2'b11;
    repeat (14) @(posedge clk);
    #1 valid = 2'b00;
    repeat (4) @(posedge clk);
    #1;
    chk("t2_accepts", 32'(acc_log.size() >= 4), 32'd1);
    if (acc_log.size() >= 4) begin
      chk("t2_order0", 32'(acc_log[0]), 32'd0);
      chk("t2_order1", 32'(acc_log[1]), 32'd1);
      chk("t2_order2", 32'(acc_log[2]), 32'd0);
      chk("t2_order3", 32'(acc_log[3]), 32'd1);
    end
    chk("t2_r0_result", res0, 32'd0);
    chk("t2_r0_zero", 32'(zero[0]), 32'd1);
    chk("t2_r1_result", res1, 32'hFF);

    // Divide by zero is illegal; a normal divide truncates.
    send(1, 4'd3, 32'd10, 32'd0, "t3a");
    wait_rsp(1, 32'd0, 1'b1, 1'b1, "t3a", lat);
    chk("t3a_latency", 32'(lat), 32'd2);
    send(1, 4'd3, 32'd10, 32'd3, "t3b");
    wait_rsp(1, 32'd3, 1'b0, 1'b0, "t3b", lat);

    // Multiply keeps the low 32 bits; an out-of-range opcode is illegal.
    send(0, 4'd2, 32'h1_0000, 32'h1_0000, "t4a");
    wait_rsp(0, 32'd0, 1'b1, 1'b0, "t4a", lat);
    send(0, 4'd9, 32'd1, 32'd1, "t4b");
    wait_rsp(0, 32'd0, 1'b1, 1'b1, "t4b", lat);

    // r0 back-pressures its response while r1 waits.
    rsp_ready = 2'b10;
    send(0, 4'd0, 32'd1, 32'd2, "t5");
    op_in[1] = 4'd4; a_in[1] = 32'hFF; b_in[1] = 32'h0F; valid[1] = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 10 && !ok; k++) begin
      @(negedge clk); ok = rsp_valid[0];
      @(posedge clk); #1;
    end
    chk("t5_rsp_seen", 32'(ok), 32'd1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("t5_r1_ready", 32'(ready[1]), 32'd0);
      chk("t5_busy", 32'(busy), 32'd1);
      chk("t5_r0_rsp_valid", 32'(rsp_valid[0]), 32'd1);
      chk("t5_r0_result", res0, 32'd3);
      @(posedge clk); #1;
    end
    rsp_ready[0] = 1'b1;
    @(negedge clk);
    chk("t5_consume", 32'(rsp_valid[0]), 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t5_r1_ready_after", 32'(ready[1]), 32'd1);
    chk("t5_idle", 32'(busy), 32'd0);
    acc_cyc = cyc;
    @(posedge clk); #1;
    valid[1] = 1'b0;
    wait_rsp(1, 32'h0F, 1'b0, 1'b0, "t5_r1", lat);
    rsp_ready = 2'b11;

    // Reset during ISSUE drops the transaction.
    send(0, 4'd0, 32'd9, 32'd9, "t6");
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("t6_r0_result", res0, 32'd0);
    chk("t6_r1_result", res1, 32'd0);
    chk("t6_zero", 32'(zero), 32'd0);
    chk("t6_illegal", 32'(ill), 32'd0);
    chk("t6_alu_op", 32'(alu_op), 32'd0);
    chk("t6_alu_a", alu_a, 32'd0);
    chk("t6_alu_b", alu_b, 32'd0);
    @(posedge clk); #1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("t6_no_rsp", 32'(rsp_valid), 32'd0);
      @(posedge clk); #1;
    end

    // Randomized traffic, including withdrawn requests and occasional resets.
    for (int i = 0; i < 2500; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int n = 0; n < 2; n++) begin
        valid[n]     = ($urandom_range(0, 9) < 6);
        rsp_ready[n] = ($urandom_range(0, 9) < 7);
        op_in[n] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6));
        a_in[n]  = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 50));
        b_in[n]  = ($urandom_range(0, 4) == 0) ? 32'd0
                 : (($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(1, 20)));
      end
      @(posedge clk); #1;
    end
    rst = 1'b0; valid = 2'b00; rsp_ready = 2'b11;
    repeat (8) @(posedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
